// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divide sequencer: state encoding and default sizes.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sequencer_core_step.sv
// One radix-2 restoring divide step: shift in a dividend bit, trial-subtract the divisor.
module div_core_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};

  // No borrow out of the trial subtraction means the divisor fits.
  assign quot_bit_o = ~diff[WIDTH];
  assign rem_o      = quot_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage DIV/DIVU sequencer: latches operand magnitudes, runs one restoring step
// per cycle, applies sign fixup and holds the pipeline until the result is ready.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_validE,
  input  logic             div_signE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             stall_otherE,
  output logic             div_stallE,
  output logic             div_doneE,
  output logic [WIDTH-1:0] quotE,
  output logic [WIDTH-1:0] remE
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             quot_neg_q, rem_neg_q;

  logic             start;
  logic             last_step;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign start     = div_validE & ~flushE;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign abs_a     = (div_signE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign abs_b     = (div_signE & srcbE[WIDTH-1]) ? -srcbE : srcbE;

  div_core_step #(.WIDTH(WIDTH)) u_step (
    .rem_i         (r_q),
    .dividend_bit_i(a_q[WIDTH-1]),
    .divisor_i     (b_q),
    .rem_o         (step_rem),
    .quot_bit_o    (step_qbit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom of the same register.
  assign a_next = {a_q[WIDTH-2:0], step_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (flushE) state_d = IDLE;
               else if (last_step) state_d = DONE;
      DONE:    if (flushE || !stall_otherE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_stallE = 1'b0;
    div_doneE  = 1'b0;
    case (state_q)
      IDLE:    div_stallE = start;
      BUSY:    div_stallE = ~flushE;
      DONE:    div_doneE  = ~flushE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= abs_a;
            b_q        <= abs_b;
            r_q        <= '0;
            cnt_q      <= '0;
            quot_neg_q <= div_signE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            rem_neg_q  <= div_signE & srcaE[WIDTH-1];
          end
        end
        BUSY: begin
          if (!flushE) begin
            a_q   <= a_next;
            r_q   <= step_rem;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
              quot_q <= quot_neg_q ? -a_next : a_next;
              rem_q  <= rem_neg_q ? -step_rem : step_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign quotE = quot_q;
  assign remE  = rem_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        div_validE;
  logic        div_signE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stall_otherE;
  logic        div_stallE;
  logic        div_doneE;
  logic [31:0] quotE;
  logic [31:0] remE;

  int checks   = 0;
  int failures = 0;

  div_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .div_validE  (div_validE),
    .div_signE   (div_signE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .flushE      (flushE),
    .stall_otherE(stall_otherE),
    .div_stallE  (div_stallE),
    .div_doneE   (div_doneE),
    .quotE       (quotE),
    .remE        (remE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // MIPS divide semantics: truncating division, remainder takes the dividend's sign,
  // divide-by-zero gives all-ones magnitude quotient and the dividend magnitude as remainder.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (!s) begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
        q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        r = a;
      end else begin
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
      end
    end
  endfunction

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit gap);
    logic [31:0] eq, er;
    int sc;
    model(s, a, b, eq, er);
    @(posedge clk); #1;
    div_validE   = 1'b1;
    div_signE    = s;
    srcaE        = a;
    srcbE        = b;
    stall_otherE = (hold > 0);
    sc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!div_stallE) break;
      sc++;
    end
    check("stall_cycles", 32'(sc), 32'd33);
    check("done_first", 32'(div_doneE), 32'd1);
    check("quot", quotE, eq);
    check("rem", remE, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", 32'(div_doneE), 32'd1);
      check("hold_no_restart", 32'(div_stallE), 32'd0);
      check("hold_quot", quotE, eq);
      check("hold_rem", remE, er);
    end
    stall_otherE = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
      div_validE = 1'b0;
      @(negedge clk);
      check("done_drop", 32'(div_doneE), 32'd0);
      check("idle_stall", 32'(div_stallE), 32'd0);
    end
    $display("div sign=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h stall=%0d hold=%0d",
             s, a, b, quotE, remE, sc, hold);
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb;
    int          mode;
    bit          saw_done;

    rst = 1'b1; div_validE = 1'b0; div_signE = 1'b0; srcaE = '0; srcbE = '0;
    flushE = 1'b0; stall_otherE = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(div_stallE), 32'd0);
    check("rst_done", 32'(div_doneE), 32'd0);
    check("rst_quot", quotE, 32'd0);
    check("rst_rem", remE, 32'd0);

    run_div(1'b0, 32'd100, 32'd7, 0, 1'b1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b1);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_div(1'b0, 32'd5, 32'd0, 0, 1'b1);
    run_div(1'b1, 32'hFFFF_FFF6, 32'd0, 0, 1'b1);
    run_div(1'b0, 32'd1000, 32'd10, 3, 1'b1);
    // Back-to-back: second divide issues the cycle after DONE -> IDLE.
    run_div(1'b0, 32'd77, 32'd8, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FF00, 32'd3, 0, 1'b1);

    // Flush at BUSY cycle 10.
    @(posedge clk); #1;
    div_validE = 1'b1; div_signE = 1'b0; srcaE = 32'd12345; srcbE = 32'd17;
    repeat (11) @(negedge clk);
    flushE = 1'b1;
    #1;
    check("flush_stall_comb", 32'(div_stallE), 32'd0);
    @(posedge clk); #1;
    flushE = 1'b0; div_validE = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_doneE || div_stallE) saw_done = 1'b1;
    end
    check("flush_no_done", 32'(saw_done), 32'd0);
    $display("flush at busy cycle 10 -> stall=%0d done=%0d", div_stallE, div_doneE);

    // Reset at BUSY cycle 20, then a fresh divide.
    @(posedge clk); #1;
    div_validE = 1'b1; div_signE = 1'b1; srcaE = 32'hFFFF_0000; srcbE = 32'd13;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; div_validE = 1'b0;
    @(negedge clk);
    check("midrst_stall", 32'(div_stallE), 32'd0);
    check("midrst_done", 32'(div_doneE), 32'd0);
    check("midrst_quot", quotE, 32'd0);
    check("midrst_rem", remE, 32'd0);
    $display("reset at busy cycle 20 -> q=0x%08h r=0x%08h", quotE, remE);
    run_div(1'b0, 32'd9, 32'd3, 0, 1'b1);

    for (int n = 0; n < 16; n++) begin
      rs   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) rb = $urandom_range(1, 15);
      else if (mode == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 3) rb = rb >> $urandom_range(8, 28);
      run_div(rs, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    div_validE = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
